// File: rtl/glyph_renderer_pkg.sv
// glyph_renderer_pkg: shared geometry, text-word layout, pipeline latency and colour expansion
package glyph_renderer_pkg;
  localparam int COLS_D = 100;
  localparam int ROWS_D = 37;
  localparam int CELL_W = 8;
  localparam int CELL_H = 16;
  localparam int CODE_LSB = 0;
  localparam int FG_LSB = 8;
  localparam int BG_LSB = 11;
  localparam int BLINK_POS = 14;
  localparam int LATENCY = 3;
  typedef struct packed {
    logic blink;
    logic [2:0] bg;
    logic [2:0] fg;
  } attr_t;
  typedef struct packed {
    logic de;
    logic [5:0] row;
    logic [7:0] col;
    logic [3:0] line;
    logic [2:0] hidx;
  } pos_t;
  function automatic logic [5:0] expand(input logic [2:0] c);
    return {{2{c[2]}}, {2{c[1]}}, {2{c[0]}}};
  endfunction
endpackage

// File: rtl/glyph_renderer_if.sv
// glyph_renderer_if: text RAM and font ROM read ports (data valid one cycle after address)
interface glyph_renderer_if;
  logic [11:0] text_addr;
  logic [15:0] text_data;
  logic [11:0] font_addr;
  logic [7:0] font_data;
  modport master (output text_addr, output font_addr, input text_data, input font_data);
  modport slave (input text_addr, input font_addr, output text_data, output font_data);
endinterface

// File: rtl/glyph_delay_line.sv
// glyph_delay_line: N-stage W-bit shift register with synchronous reset
module glyph_delay_line #(
  parameter int W = 1,
  parameter int N = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [N*W-1:0] sr;
  always_ff @(posedge clk)
    sr <= reset ? '0 : (N*W)'({sr, d});
  assign q = sr[N*W-1 -: W];
endmodule

// File: rtl/glyph_renderer.sv
// glyph_renderer: 800x600 text-mode pixel pipeline, rgb 3 cycles after hpos/vpos
module glyph_renderer
  import glyph_renderer_pkg::*;
#(
  parameter int COLS = COLS_D,
  parameter int ROWS = ROWS_D,
  parameter int BLINK_BIT = 5
) (
  input  logic clk,
  input  logic reset,
  input  logic [10:0] hpos,
  input  logic [9:0] vpos,
  input  logic display_on,
  input  logic hsync,
  input  logic vsync,
  glyph_renderer_if.master mem,
  input  logic cursor_en,
  input  logic [6:0] cursor_col,
  input  logic [5:0] cursor_row,
  output logic [5:0] rgb,
  output logic hsync_o,
  output logic vsync_o,
  output logic display_on_o
);
  localparam int HB = $clog2(CELL_W);
  localparam int VB = $clog2(CELL_H);
  localparam logic [7:0] COLS_W = 8'(COLS);
  localparam logic [5:0] ROWS_W = 6'(ROWS);
  pos_t p0, p1, p2;
  attr_t a2;
  logic [$bits(pos_t)+$bits(attr_t)-1:0] s2_q;
  logic [2:0] sync_q;
  logic [11:0] r;
  logic [5:0] frame_cnt;
  logic cur_on;
  logic [6:0] cur_col;
  logic [5:0] cur_row;
  logic blink_phase, cur_hit, pix, unused_reserved;
  assign p0 = '{de: display_on, row: vpos[9:VB], col: hpos[10:HB], line: vpos[VB-1:0], hidx: hpos[HB-1:0]};
  assign r = 12'(p0.row);
  assign mem.text_addr = (COLS == 100 ? (r << 6) + (r << 5) + (r << 2) : r * 12'(COLS)) + 12'(p0.col);
  glyph_delay_line #(.W($bits(pos_t)), .N(1)) u_s1 (.clk(clk), .reset(reset), .d(p0), .q(p1));
  assign mem.font_addr = {mem.text_data[CODE_LSB +: 8], p1.line};
  glyph_delay_line #(.W($bits(pos_t) + $bits(attr_t)), .N(1)) u_s2 (
    .clk(clk), .reset(reset),
    .d({p1, mem.text_data[BLINK_POS], mem.text_data[BG_LSB +: 3], mem.text_data[FG_LSB +: 3]}),
    .q(s2_q)
  );
  assign {p2, a2} = s2_q;
  glyph_delay_line #(.W(3), .N(LATENCY)) u_sync (
    .clk(clk), .reset(reset), .d({hsync, vsync, display_on}), .q(sync_q)
  );
  assign {hsync_o, vsync_o, display_on_o} = sync_q;
  assign unused_reserved = mem.text_data[15];
  // cursor position is frozen at the frame tick so mid-frame writes wait for the next frame
  always_ff @(posedge clk)
    if (reset) begin
      frame_cnt <= '0;
      cur_on <= 1'b0;
      cur_col <= '0;
      cur_row <= '0;
    end else if (hpos == 11'd0 && vpos == 10'd600) begin
      frame_cnt <= frame_cnt + 6'd1;
      cur_on <= cursor_en && {1'b0, cursor_col} < COLS_W && cursor_row < ROWS_W;
      cur_col <= cursor_col;
      cur_row <= cursor_row;
    end
  assign blink_phase = frame_cnt[BLINK_BIT];
  assign cur_hit = cur_on && p2.row == cur_row && p2.col == {1'b0, cur_col} && p2.line[3:1] == 3'b111 && !blink_phase;
  assign pix = cur_hit || (mem.font_data[~p2.hidx] && !(a2.blink && blink_phase));
  always_ff @(posedge clk)
    rgb <= reset ? '0 : (p2.de && p2.row < ROWS_W) ? expand(pix ? a2.fg : a2.bg) : '0;
endmodule

// File: tb/tb_glyph_renderer.sv
// tb_glyph_renderer: directed plus randomized checks against a per-pixel reference model
module tb_glyph_renderer;
  logic clk = 1'b0;
  logic reset;
  logic [10:0] hpos;
  logic [9:0] vpos;
  logic display_on, hsync, vsync;
  logic cursor_en;
  logic [6:0] cursor_col;
  logic [5:0] cursor_row;
  logic [5:0] rgb;
  logic hsync_o, vsync_o, display_on_o;
  glyph_renderer_if mem();

  glyph_renderer dut (
    .clk(clk), .reset(reset), .hpos(hpos), .vpos(vpos), .display_on(display_on),
    .hsync(hsync), .vsync(vsync), .mem(mem), .cursor_en(cursor_en),
    .cursor_col(cursor_col), .cursor_row(cursor_row), .rgb(rgb),
    .hsync_o(hsync_o), .vsync_o(vsync_o), .display_on_o(display_on_o)
  );

  always #5 clk = ~clk;

  logic [15:0] text_ram [4096];
  logic [7:0] font_rom [4096];
  always @(posedge clk) begin
    mem.text_data <= text_ram[mem.text_addr];
    mem.font_data <= font_rom[mem.font_addr];
  end

  int passed = 0;
  int total = 0;
  int m_frame = 0;
  int m_cc = 0;
  int m_cr = 0;
  bit m_cur_on = 0;
  logic [8:0] expq [$];

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [5:0] ref_rgb(int h, int v, bit de);
    int row, col, line, c;
    logic [15:0] w;
    logic [7:0] g;
    bit pix, bp;
    row = v / 16;
    col = h / 8;
    line = v % 16;
    if (!de || row >= 37) return 6'd0;
    w = text_ram[(row * 100 + col) % 4096];
    g = font_rom[int'(w[7:0]) * 16 + line];
    pix = g[7 - h % 8];
    bp = (m_frame / 32) % 2 == 1;
    if (w[14] && bp) pix = 0;
    if (m_cur_on && col == m_cc && row == m_cr && line >= 14 && !bp) pix = 1;
    c = pix ? int'(w[10:8]) : int'(w[13:11]);
    return 6'((c / 4) * 48 + ((c / 2) % 2) * 12 + (c % 2) * 3);
  endfunction

  task automatic drive(int h, int v, bit de, bit hs, bit vs);
    hpos = 11'(h);
    vpos = 10'(v);
    display_on = de;
    hsync = hs;
    vsync = vs;
    expq.push_back({ref_rgb(h, v, de), hs, vs, de});
    if (h == 0 && v == 600) begin
      m_frame = (m_frame + 1) % 64;
      m_cur_on = cursor_en && cursor_col < 100 && cursor_row < 37;
      m_cc = int'(cursor_col);
      m_cr = int'(cursor_row);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (expq.size() > 0)
      chk("pipe", 32'({rgb, hsync_o, vsync_o, display_on_o}), 32'(expq.pop_front()));
  endtask

  task automatic cyc(int h, int v, bit de, bit hs, bit vs);
    drive(h, v, de, hs, vs);
    tick();
  endtask

  task automatic probe(int h, int v, logic [5:0] e, string tag);
    cyc(h, v, 1, 0, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    chk(tag, 32'(rgb), 32'(e));
  endtask

  task automatic frames(int n);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    repeat (n) cyc(0, 600, 0, 0, 0);
  endtask

  task automatic do_reset();
    reset = 1;
    hpos = '0;
    vpos = '0;
    display_on = 0;
    hsync = 0;
    vsync = 0;
    @(posedge clk);
    #1;
    chk("reset_out", 32'({rgb, hsync_o, vsync_o, display_on_o}), 32'(0));
    reset = 0;
    expq.delete();
    expq.push_back(9'd0);
    expq.push_back(9'd0);
    m_frame = 0;
    m_cur_on = 0;
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 4096; i++) begin
      text_ram[i] = 16'($urandom);
      font_rom[i] = 8'($urandom);
    end
    text_ram[202] = 16'h0741;
    font_rom[12'h413] = 8'h81;
    text_ram[3702] = 16'h07FF;
    font_rom[12'hFF3] = 8'hFF;
    text_ram[205] = 16'h0C20;
    text_ram[300] = 16'h0C20;
    font_rom[12'h20F] = 8'h00;
    font_rom[12'h20D] = 8'h00;
    text_ram[206] = 16'h4721;
    font_rom[12'h215] = 8'hFF;
    cursor_en = 0;
    cursor_col = '0;
    cursor_row = '0;
    reset = 1;
    repeat (3) @(posedge clk);
    do_reset();

    drive(16, 35, 1, 0, 0);
    tick();
    drive(17, 35, 1, 0, 0);
    #1;
    chk("text_addr", 32'(mem.text_addr), 32'(202));
    tick();
    chk("font_addr", 32'(mem.font_addr), 32'(12'h413));
    cyc(0, 0, 0, 0, 0);
    chk("pix_hidx0", 32'(rgb), 32'(6'h3F));
    cyc(0, 0, 0, 0, 0);
    chk("pix_hidx1", 32'(rgb), 32'(0));

    cyc(100, 100, 1, 1, 1);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    chk("sync_on", 32'({hsync_o, vsync_o, display_on_o}), 32'(3'b111));
    cyc(0, 0, 0, 0, 0);
    chk("sync_off", 32'({hsync_o, vsync_o, display_on_o}), 32'(3'b000));

    probe(16, 595, 6'h00, "blank_row");

    cursor_en = 1;
    cursor_col = 7'd5;
    cursor_row = 6'd2;
    probe(40, 47, 6'h03, "cur_unlatched");
    frames(1);
    probe(40, 47, 6'h30, "cur_on");
    probe(40, 45, 6'h03, "cur_line13");
    probe(48, 37, 6'h3F, "blink_visible");
    frames(31);
    probe(40, 47, 6'h03, "cur_blinked");
    probe(48, 37, 6'h00, "blink_hidden");
    frames(32);
    probe(40, 47, 6'h30, "cur_wrap");
    cursor_col = 7'd100;
    frames(1);
    probe(800, 47, 6'h03, "cur_out_of_range");

    for (int i = 0; i < 1500; i++) begin
      int h, v;
      if (i % 250 == 0) begin
        cursor_en = $urandom_range(0, 3) != 0;
        cursor_col = 7'($urandom_range(0, 110));
        cursor_row = 6'($urandom_range(0, 40));
        frames($urandom_range(1, 40));
      end
      if ($urandom_range(0, 3) == 0) begin
        h = int'(cursor_col) * 8 + $urandom_range(0, 7);
        v = int'(cursor_row) * 16 + 14 + $urandom_range(0, 1);
      end else begin
        h = $urandom_range(0, 1055);
        v = $urandom_range(0, 627);
        if (v == 600) v = 601;
      end
      cyc(h, v, $urandom_range(0, 7) != 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    repeat (4) cyc(100, 100, 1, 1, 1);
    do_reset();
    probe(16, 35, 6'h3F, "post_reset");
    repeat (3) cyc(0, 0, 0, 0, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/glyph_renderer.md
GLYPH_RENDERER -- requirements
Module: glyph_renderer

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- COLS, 100, text columns (8-px cells across 800 px)
- ROWS, 37, text rows (16-line cells; lines 592..599 are blank)
- BLINK_BIT, 5, frame-counter bit that sets the blink phase
REQ-002 Ports, one per line: name, direction, width, meaning.
- clk, in, 1, pixel clock (40 MHz); the only clock
- reset, in, 1, synchronous, active-high
- hpos, in, 11, horizontal position from the sync generator
- vpos, in, 10, vertical position from the sync generator
- display_on, in, 1, active-area flag from the sync generator
- hsync, in, 1, horizontal sync (positive polarity)
- vsync, in, 1, vertical sync (positive polarity)
- text_addr, out, 12, text RAM read address (row*COLS+col)
- text_data, in, 16, text word: [7:0] code, [10:8] fg, [13:11] bg, [14] blink, [15] reserved; valid 1 cycle after address
- font_addr, out, 12, font ROM address {code, glyph_line[3:0]}
- font_data, in, 8, glyph row, bit 7 is the leftmost pixel; valid 1 cycle after address
- cursor_en, in, 1, cursor enable
- cursor_col, in, 7, cursor column
- cursor_row, in, 6, cursor row
- rgb, out, 6, {R1,R0,G1,G0,B1,B0}, registered
- hsync_o, out, 1, hsync delayed to match rgb
- vsync_o, out, 1, vsync delayed to match rgb
- display_on_o, out, 1, display_on delayed to match rgb

Function
REQ-003 Stage 0 (cycle T) SHALL drive text_addr = vpos[9:4]*COLS + hpos[10:3]; the multiply is shift-add (r<<6)+(r<<5)+(r<<2) in 12 bits. The address is don't-care outside the active area.
REQ-004 Stage 1 (T+1) SHALL drive font_addr = {text_data[7:0], vpos_d1[3:0]} and register the attributes, pixel index hpos[2:0], cell row/col and display_on.
REQ-005 Stage 2 (T+2) SHALL select pix = font_data[7 - hidx].
REQ-006 At T+3 rgb SHALL present the pixel colour.
- rgb latency from hpos/vpos is exactly 3 cycles.
- hsync_o, vsync_o and display_on_o SHALL be delayed by the same 3 cycles.
REQ-007 Colour mapping: a 3-bit colour {r,g,b} SHALL map to rgb = {r,r,g,g,b,b}; the foreground is used when pix=1, the background otherwise.
REQ-008 rgb SHALL be 0 when the delayed display_on is 0 or the delayed cell row is >= ROWS.
REQ-009 Frame counter:
- 6-bit frame_cnt SHALL increment in the cycle where hpos==0 and vpos==600.
- frame_cnt wraps 63 to 0.
- blink_phase = frame_cnt[BLINK_BIT].
REQ-010 Attribute blink: when the blink bit is 1 and blink_phase is 1, pix SHALL be forced to 0.
REQ-011 Cursor:
- Condition: cursor_en=1, the cell equals (cursor_col, cursor_row), the glyph line is 14 or 15, and blink_phase=0.
- When the condition holds, pix SHALL be forced to 1.
- The cursor overrides attribute blink.
- A cursor_row >= ROWS or cursor_col >= COLS SHALL show no cursor.
REQ-012 cursor_* inputs SHALL be sampled once per frame, in the same cycle as the frame_cnt update, so a mid-frame change takes effect at the next frame.
REQ-013 The pipeline SHALL run every cycle with no stall; hpos wrap and vpos wrap need no special handling beyond REQ-008.

Reset
REQ-014 While reset=1, at the next clk edge:
- rgb=0, hsync_o=0, vsync_o=0, display_on_o=0.
- All pipeline registers cleared (display_on stages=0, sync stages=0).
- frame_cnt=0, latched cursor cleared (no cursor shown).
REQ-015 A reset asserted mid-frame SHALL blank output for the 3 pipeline cycles after release; valid video resumes on the 4th cycle.

Structure
REQ-016 A shared package SHALL hold COLS, ROWS, the cell size (8x16), the text-word field positions, the pipeline latency (3) and the colour-expand function.
REQ-017 One sub-module, glyph_delay_line (a parametric N-stage shift register with reset), SHALL carry the sync, display_on and attribute bits.

Verification
REQ-018 Directed scenarios the bench SHALL cover:
- Address: hpos=17, vpos=35 -> text_addr=2*100+2=202 the same cycle; font_addr={code,4'd3} at T+1.
- Pixel: text_data=0x0741 (code 0x41, fg 7, bg 0), font_data=0x81, hidx 0 -> rgb=6'h3F at T+3; hidx 1 -> rgb=0.
- Sync: a 1-cycle hsync pulse at T -> hsync_o pulse at T+3; display_on_o tracks with the same 3-cycle delay.
- Blank rows: vpos=595, display_on=1 -> rgb=0 whatever the font data.
- Cursor/blink: cursor at (5,2), glyph line 15, frame_cnt=0 -> rgb=fg; after 32 frames -> bg. A blink-attribute cell shows bg during frames 32..63.
- Reset: reset pulsed mid-line -> all outputs 0 at the next edge; rgb valid 3 cycles after release.
